chart_scheduler: RTL and testbench

- Sequences the arrow lanes from the chart memory (chart.hex).
- Fetches one chart entry per note and holds it until the matching beat-grid tick from the timing block.
- On that tick, issues a one-cycle launch pulse to each selected lane's arrow movement unit, then advances the read address.
- Replaces the free-running launch gating and OR-ed next strobe. Sits between the chart RAM, the timing block and the four lane movement units.

---
 rtl/chart_scheduler.sv | 129 ++++++++++++
 tb/tb_chart_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/chart_scheduler.sv
// Chart scheduler: steps through the chart RAM one entry at a time, arms each entry
// until its beat-grid tick arrives, then pulses the selected lane launch lines.
module chart_scheduler #(
    parameter int ADDR_W    = 8,
    parameter int CHART_LEN = 256,
    parameter int CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              pause_i,
    input  logic              quarter_i,
    input  logic              eigth_i,
    input  logic              sixteenth_i,
    input  logic [3:0]        lane_full_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [7:0]        rd_data_i,
    output logic [3:0]        launch_o,
    output logic              drop_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  note_count_o,
    output logic [CNT_W-1:0]  drop_count_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_ARM    = 3'd3;
    localparam logic [2:0] ST_LAUNCH = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHART_LEN - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        entry;
    logic [3:0]        launch;
    logic              drop;
    logic [CNT_W-1:0]  note_count;
    logic [CNT_W-1:0]  drop_count;

    logic [3:0] arrows;
    logic [3:0] timing;
    logic       match;
    logic       fire;
    logic [3:0] go;
    logic [3:0] lost;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [3:0] bits);
        logic [CNT_W:0] sum;
        sum = {1'b0, base} + (CNT_W+1)'(bits[0]) + (CNT_W+1)'(bits[1])
                           + (CNT_W+1)'(bits[2]) + (CNT_W+1)'(bits[3]);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // Entries with no quarter/eighth bit fall back to the sixteenth grid.
    always_comb begin
        arrows = entry[7:4];
        timing = entry[3:0];
        if (timing[3:2] == 2'b00) begin
            match = sixteenth_i;
        end else begin
            match = (quarter_i & timing[2]) | (eigth_i & timing[3])
                  | (sixteenth_i & (timing == 4'hF));
        end
        fire = (state == ST_ARM) && match && !pause_i;
        go   = arrows & ~lane_full_i;
        lost = arrows & lane_full_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= ST_IDLE;
            addr       <= '0;
            entry      <= '0;
            launch     <= '0;
            drop       <= 1'b0;
            note_count <= '0;
            drop_count <= '0;
        end else begin
            launch <= '0;
            drop   <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        addr  <= '0;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_WAIT;
                ST_WAIT: begin
                    entry <= rd_data_i;
                    state <= (rd_data_i == 8'h00) ? ST_DONE : ST_ARM;
                end
                ST_ARM: begin
                    if (fire) begin
                        launch     <= go;
                        drop       <= |lost;
                        note_count <= sat_add(note_count, go);
                        drop_count <= sat_add(drop_count, lost);
                        state      <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (addr == LAST_ADDR) begin
                        state <= ST_DONE;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rd_en_o      = (state == ST_FETCH);
    assign rd_addr_o    = addr;
    assign launch_o     = launch;
    assign drop_o       = drop;
    assign busy_o       = (state != ST_IDLE) && (state != ST_DONE);
    assign done_o       = (state == ST_DONE);
    assign note_count_o = note_count;
    assign drop_count_o = drop_count;

endmodule

// File: tb/tb_chart_scheduler.sv
// Randomized bench for chart_scheduler: per-cycle ticks, pauses and lane-full flags are
// generated up front and a timeline model predicts every launch, drop and counter value.
module tb_chart_scheduler;

    localparam int AW  = 3;
    localparam int LEN = 8;
    localparam int CW  = 4;
    localparam int N   = 400;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          reset_i, start_i, pause_i, quarter_i, eigth_i, sixteenth_i;
    logic [3:0]    lane_full_i;
    logic          rd_en_o;
    logic [AW-1:0] rd_addr_o;
    logic [7:0]    rd_data_i;
    logic [3:0]    launch_o;
    logic          drop_o, busy_o, done_o;
    logic [CW-1:0] note_count_o, drop_count_o;

    chart_scheduler #(.ADDR_W(AW), .CHART_LEN(LEN), .CNT_W(CW)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .pause_i(pause_i),
        .quarter_i(quarter_i), .eigth_i(eigth_i), .sixteenth_i(sixteenth_i),
        .lane_full_i(lane_full_i), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
        .rd_data_i(rd_data_i), .launch_o(launch_o), .drop_o(drop_o), .busy_o(busy_o),
        .done_o(done_o), .note_count_o(note_count_o), .drop_count_o(drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] chart [LEN];

    // Chart RAM: one cycle read latency.
    always @(posedge clk_i) begin
        if (rd_en_o) rd_data_i <= chart[rd_addr_o];
    end

    bit         q_v [N], e_v [N], s_v [N], p_v [N], start_v [N], rst_v [N];
    logic [3:0] full_v [N];

    logic [3:0]    exp_launch [N];
    bit            exp_drop [N], exp_rden [N], exp_busy [N], exp_done [N];
    bit            is_launch [N], addr_chk [N];
    logic [AW-1:0] exp_addr [N];
    int            dn [N], dd [N], exp_nc [N], exp_dc [N];

    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    endtask

    function automatic bit refMatch(int c, logic [3:0] t);
        if (t[3:2] == 2'b00) return s_v[c];
        return (q_v[c] && t[2]) || (e_v[c] && t[3]) || (s_v[c] && t == 4'hF);
    endfunction

    // Walks the chart as a timeline: start at c fetches at c+1, the entry is armed at
    // fetch+2, a match at m launches at m+1 and the next fetch is at m+2.
    task automatic buildModel(input int rr);
        int c, f, m, a, nc, dc;
        bit isDone;
        logic [AW-1:0] doneAddr;
        logic [7:0] ent;
        for (int i = 0; i < N; i++) begin
            exp_launch[i] = '0; exp_drop[i] = 0; exp_rden[i] = 0; exp_busy[i] = 0;
            exp_done[i] = 0; is_launch[i] = 0; addr_chk[i] = 0; exp_addr[i] = '0;
            dn[i] = 0; dd[i] = 0;
        end
        c = 0; isDone = 0; doneAddr = '0;
        while (c < N) begin
            exp_done[c] = isDone;
            exp_addr[c] = isDone ? doneAddr : '0;
            addr_chk[c] = 1;
            if (!start_v[c]) begin
                c++;
                continue;
            end
            a = 0; f = c + 1; c = N;
            while (f < N) begin
                exp_busy[f] = 1; exp_rden[f] = 1; exp_addr[f] = AW'(a); addr_chk[f] = 1;
                if (f + 1 < N) exp_busy[f+1] = 1;
                ent = chart[a];
                if (ent == 8'h00) begin
                    c = f + 2; doneAddr = AW'(a);
                    break;
                end
                m = f + 2;
                while (m < N && !(refMatch(m, ent[3:0]) && !p_v[m])) begin
                    exp_busy[m] = 1;
                    m++;
                end
                if (m >= N) break;
                exp_busy[m] = 1;
                if (m + 1 < N) begin
                    exp_busy[m+1]   = 1;
                    exp_launch[m+1] = ent[7:4] & ~full_v[m];
                    exp_drop[m+1]   = |(ent[7:4] & full_v[m]);
                    is_launch[m+1]  = 1;
                    dn[m+1] = $countones(ent[7:4] & ~full_v[m]);
                    dd[m+1] = $countones(ent[7:4] & full_v[m]);
                end
                if (a == LEN - 1) begin
                    c = m + 2; doneAddr = AW'(a);
                    break;
                end
                a++;
                f = m + 2;
            end
            isDone = 1;
        end
        nc = 0; dc = 0;
        for (int i = 0; i < N; i++) begin
            nc = (nc + dn[i] > CMAX) ? CMAX : nc + dn[i];
            dc = (dc + dd[i] > CMAX) ? CMAX : dc + dd[i];
            exp_nc[i] = nc; exp_dc[i] = dc;
        end
        if (rr >= 0) begin
            for (int i = rr + 1; i < N; i++) begin
                exp_launch[i] = '0; exp_drop[i] = 0; exp_rden[i] = 0; exp_busy[i] = 0;
                exp_done[i] = 0; is_launch[i] = 0; addr_chk[i] = 1; exp_addr[i] = '0;
                exp_nc[i] = 0; exp_dc[i] = 0;
            end
        end
    endtask

    task automatic applyStimulus(input int ep);
        bit pz;
        int rr;
        pz = 0;
        rr = (ep == 3) ? 250 : -1;
        for (int i = 0; i < LEN; i++) begin
            case (ep)
                0: chart[i] = (i == 0) ? 8'h84 : (i == 1) ? 8'h48 : (i == 2) ? 8'h00
                                                                            : 8'($urandom);
                1: chart[i] = (i == 0) ? 8'hF4 : (i == 1) ? 8'hAF : (i == 2) ? 8'h44 : 8'h00;
                5: chart[i] = 8'hF0;
                default: chart[i] = 8'($urandom_range(1, 255));
            endcase
        end
        if (ep == 3) chart[$urandom_range(2, LEN - 1)] = 8'h00;
        for (int c = 0; c < N; c++) begin
            q_v[c] = ($urandom_range(0, 9) == 0);
            e_v[c] = ($urandom_range(0, 6) == 0);
            s_v[c] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) pz = !pz;
            p_v[c] = pz;
            full_v[c] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            start_v[c] = (c == 2) || ($urandom_range(0, 29) == 0);
            if (rr >= 0 && c > rr) start_v[c] = 0;
            rst_v[c] = (c == rr);
        end
        buildModel(rr);

        @(negedge clk_i);
        reset_i = 1; start_i = 0; pause_i = 0; quarter_i = 0; eigth_i = 0;
        sixteenth_i = 0; lane_full_i = '0;
        for (int c = 0; c < N; c++) begin
            @(negedge clk_i);
            checkOutput($sformatf("e%0d c%0d launch", ep, c), 32'(launch_o), 32'(exp_launch[c]));
            checkOutput($sformatf("e%0d c%0d drop", ep, c), 32'(drop_o), 32'(exp_drop[c]));
            checkOutput($sformatf("e%0d c%0d rd_en", ep, c), 32'(rd_en_o), 32'(exp_rden[c]));
            checkOutput($sformatf("e%0d c%0d busy", ep, c), 32'(busy_o), 32'(exp_busy[c]));
            checkOutput($sformatf("e%0d c%0d done", ep, c), 32'(done_o), 32'(exp_done[c]));
            if (addr_chk[c])
                checkOutput($sformatf("e%0d c%0d rd_addr", ep, c), 32'(rd_addr_o),
                            32'(exp_addr[c]));
            if (!is_launch[c]) begin
                checkOutput($sformatf("e%0d c%0d notes", ep, c), 32'(note_count_o),
                            32'(exp_nc[c]));
                checkOutput($sformatf("e%0d c%0d drops", ep, c), 32'(drop_count_o),
                            32'(exp_dc[c]));
            end
            reset_i     = rst_v[c];
            start_i     = start_v[c];
            pause_i     = p_v[c];
            quarter_i   = q_v[c];
            eigth_i     = e_v[c];
            sixteenth_i = s_v[c];
            lane_full_i = full_v[c];
        end
    endtask

    initial begin
        reset_i = 1; start_i = 0; pause_i = 0; quarter_i = 0; eigth_i = 0;
        sixteenth_i = 0; lane_full_i = '0;
        for (int ep = 0; ep < 6; ep++) begin
            applyStimulus(ep);
        end
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
